cart_bank_ctrl: RTL and testbench

Cartridge mapper controller between the 6502 address bus and the 32 KB cartridge ROM/RAM.
- Infers cartridge size from loader writes.
- Selects the bank-switching scheme: none, F8, FE, F6 or F4.
- Detects hotspot accesses on each CPU bus cycle and drives the banked ROM address.
- Optionally provides Superchip cart-RAM selects.

---
 rtl/cart_bank_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_cart_bank_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cart_bank_ctrl.sv
// cart_bank_ctrl
//   Cartridge mapper between the 6502 address bus and a 32 KB cartridge
//   ROM/RAM. Works out the cartridge size from loader writes, picks the
//   bank-switching scheme (none 2K/4K, F8, FE, F6, F4), watches every CPU bus
//   cycle for hotspot accesses and drives the banked ROM address.
//
//   Optional feature macro: SUPERCHIP_EN
//     defined   -> adds input sc_en and drives Superchip cart-RAM selects
//     undefined -> cart_ram_cs / cart_ram_we tied low
//
// Ports
//   clk_sys, reset     system clock, synchronous active-high reset
//   cpu_strobe         one-cycle pulse per CPU bus cycle
//   cpu_addr/rnw/data  CPU bus (13-bit address, 1 = read, 8-bit data)
//   fe_sel             8 KB carts: 1 = FE scheme, 0 = F8 scheme
//   sc_en              (SUPERCHIP_EN only) enable Superchip RAM
//   ld_active          loader owns the ROM; hotspots ignored, bank held at 0
//   ld_wr, ld_addr     loader write strobe/address, used to infer cart size
//   rom_addr           registered banked ROM address
//   bank               current bank register
//   scheme             0 none2K, 1 none4K, 2 F8, 3 FE, 4 F6, 5 F4
//   cart_ram_cs/we     Superchip RAM select / write enable (combinational)

module cart_bank_ctrl #(
  parameter int BANK_W = 3,
  parameter int ROM_AW = 15
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cpu_strobe,
  input  logic [12:0]       cpu_addr,
  input  logic              cpu_rnw,
  input  logic [7:0]        cpu_data,
  input  logic              fe_sel,
`ifdef SUPERCHIP_EN
  input  logic              sc_en,
`endif
  input  logic              ld_active,
  input  logic              ld_wr,
  input  logic [ROM_AW-1:0] ld_addr,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [BANK_W-1:0] bank,
  output logic [2:0]        scheme,
  output logic              cart_ram_cs,
  output logic              cart_ram_we
);

  localparam logic [2:0] SZ_2K  = 3'd0;
  localparam logic [2:0] SZ_4K  = 3'd1;
  localparam logic [2:0] SZ_8K  = 3'd2;
  localparam logic [2:0] SZ_16K = 3'd3;
  localparam logic [2:0] SZ_32K = 3'd4;

  localparam logic [2:0] SCH_2K = 3'd0;
  localparam logic [2:0] SCH_4K = 3'd1;
  localparam logic [2:0] SCH_F8 = 3'd2;
  localparam logic [2:0] SCH_FE = 3'd3;
  localparam logic [2:0] SCH_F6 = 3'd4;
  localparam logic [2:0] SCH_F4 = 3'd5;

  typedef enum logic {FE_IDLE, FE_ARMED} fe_st_e;

  // Size survives CPU reset so a reset after loading keeps the mapping;
  // the power-up value comes from the configuration image.
  logic [2:0]        sz_q = SZ_4K;
  logic [2:0]        sz_d;
  logic [2:0]        sz_grow;
  logic [2:0]        sz_base;
  logic [BANK_W-1:0] bank_q;
  fe_st_e            fe_st_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic              hot_vld;
  logic [3:0]        hot_off;
  logic [BANK_W-1:0] hot_bank;
  logic [11:0]       a_lo;

  // ---------------------------------------------------------------- size
  always_comb begin
    sz_grow = SZ_2K;
    if (ld_addr[14])      sz_grow = SZ_32K;
    else if (ld_addr[13]) sz_grow = SZ_16K;
    else if (ld_addr[12]) sz_grow = SZ_8K;
    else if (ld_addr[11]) sz_grow = SZ_4K;
    // An address-0 write restarts sizing from 2K before any growth.
    sz_base = (ld_addr == '0) ? SZ_2K : sz_q;
    sz_d    = sz_q;
    if (ld_wr) sz_d = (sz_grow > sz_base) ? sz_grow : sz_base;
  end

  always_ff @(posedge clk_sys) sz_q <= sz_d;

  // -------------------------------------------------------------- scheme
  always_comb begin
    case (sz_q)
      SZ_2K:   scheme = SCH_2K;
      SZ_4K:   scheme = SCH_4K;
      SZ_8K:   scheme = fe_sel ? SCH_FE : SCH_F8;
      SZ_16K:  scheme = SCH_F6;
      SZ_32K:  scheme = SCH_F4;
      default: scheme = SCH_4K;
    endcase
  end

  // ------------------------------------------------------------ hotspots
  assign a_lo = cpu_addr[11:0];

  always_comb begin
    hot_vld = 1'b0;
    hot_off = 4'd0;
    case (scheme)
      SCH_F8: if (cpu_addr[12] && (a_lo == 12'hFF8 || a_lo == 12'hFF9)) begin
        hot_vld = 1'b1;
        hot_off = {3'b000, a_lo[0]};
      end
      SCH_F6: if (cpu_addr[12] && a_lo >= 12'hFF6 && a_lo <= 12'hFF9) begin
        hot_vld = 1'b1;
        hot_off = a_lo[3:0] - 4'd6;
      end
      SCH_F4: if (cpu_addr[12] && a_lo >= 12'hFF4 && a_lo <= 12'hFFB) begin
        hot_vld = 1'b1;
        hot_off = a_lo[3:0] - 4'd4;
      end
      default: ;
    endcase
    hot_bank = BANK_W'(hot_off);
  end

  // ------------------------------------------------- bank register + FE FSM
  // FE only arms while the FE scheme is selected, so leaving the scheme is
  // the only "scheme change" that can happen while ARMED.
  always_ff @(posedge clk_sys) begin
    if (reset || ld_active) begin
      bank_q  <= '0;
      fe_st_q <= FE_IDLE;
    end else begin
      if (scheme != SCH_FE) fe_st_q <= FE_IDLE;
      if (cpu_strobe) begin
        if (hot_vld) bank_q <= hot_bank;
        if (scheme == SCH_FE) begin
          if (fe_st_q == FE_ARMED)
            bank_q <= cpu_data[5] ? BANK_W'(0) : BANK_W'(1);
          // A 01FE access in ARMED applies the bank and re-arms.
          fe_st_q <= (cpu_addr == 13'h01FE) ? FE_ARMED : FE_IDLE;
        end
      end
    end
  end

  // ------------------------------------------------------------ rom_addr
  // Uses the bank before this cycle's update, so the hotspot access itself
  // still reads the old bank.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rom_addr_q <= '0;
    end else begin
      case (scheme)
        SCH_2K:  rom_addr_q <= ROM_AW'(cpu_addr[10:0]);
        SCH_4K:  rom_addr_q <= ROM_AW'(cpu_addr[11:0]);
        default: rom_addr_q <= ROM_AW'({bank_q, cpu_addr[11:0]});
      endcase
    end
  end

  assign rom_addr = rom_addr_q;
  assign bank     = bank_q;

  // ----------------------------------------------------------- Superchip
`ifdef SUPERCHIP_EN
  logic sc_sch;
  assign sc_sch = (scheme == SCH_F8) || (scheme == SCH_F6) || (scheme == SCH_F4);
  // 1000-107F is the write port, 1080-10FF the read port.
  assign cart_ram_cs = ~reset & sc_en & sc_sch & (cpu_addr[12:8] == 5'b10000);
  assign cart_ram_we = ~reset & sc_en & sc_sch & cpu_strobe & ~cpu_rnw &
                       (cpu_addr[12:7] == 6'b100000);
`else
  assign cart_ram_cs = 1'b0;
  assign cart_ram_we = 1'b0;
`endif

  // Only bit 5 of the data bus matters; rnw only matters for Superchip.
  logic unused_ok;
  assign unused_ok = ^{cpu_data[7:6], cpu_data[4:0], cpu_rnw};

endmodule

// File: tb/tb_cart_bank_ctrl.sv
module tb_cart_bank_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_strobe = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic        cpu_rnw = 1'b1;
  logic [7:0]  cpu_data = '0;
  logic        fe_sel = 1'b0;
`ifdef SUPERCHIP_EN
  logic        sc_en = 1'b0;
`endif
  logic        ld_active = 1'b0;
  logic        ld_wr = 1'b0;
  logic [14:0] ld_addr = '0;
  logic [14:0] rom_addr;
  logic [2:0]  bank;
  logic [2:0]  scheme;
  logic        cart_ram_cs;
  logic        cart_ram_we;

  int n_checks = 0;
  int n_fail   = 0;

  cart_bank_ctrl #(.BANK_W(3), .ROM_AW(15)) dut (
    .clk_sys(clk_sys), .reset(reset), .cpu_strobe(cpu_strobe),
    .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_data(cpu_data),
    .fe_sel(fe_sel),
`ifdef SUPERCHIP_EN
    .sc_en(sc_en),
`endif
    .ld_active(ld_active), .ld_wr(ld_wr), .ld_addr(ld_addr),
    .rom_addr(rom_addr), .bank(bank), .scheme(scheme),
    .cart_ram_cs(cart_ram_cs), .cart_ram_we(cart_ram_we)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic load(input logic [14:0] a);
    ld_wr = 1'b1; ld_addr = a;
    tick();
    ld_wr = 1'b0;
  endtask

  task automatic strobe(input logic [12:0] a, input logic [7:0] d);
    cpu_strobe = 1'b1; cpu_addr = a; cpu_data = d; cpu_rnw = 1'b1;
    tick();
    cpu_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_checks++; if (bank !== 3'd0) begin n_fail++; $display("FAIL rst_bank got %0d exp 0", bank); end
    n_checks++; if (rom_addr !== 15'h0) begin n_fail++; $display("FAIL rst_rom got %h exp 0000", rom_addr); end
    n_checks++; if (scheme !== 3'd1) begin n_fail++; $display("FAIL rst_scheme got %0d exp 1", scheme); end
    n_checks++; if (cart_ram_cs !== 1'b0 || cart_ram_we !== 1'b0) begin
      n_fail++; $display("FAIL rst_ram got cs=%b we=%b exp 0/0", cart_ram_cs, cart_ram_we); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_f8();
    fe_sel = 1'b0;
    ld_active = 1'b1;
    load(15'h0000); load(15'h0800); load(15'h1FFF);
    n_checks++; if (scheme !== 3'd2) begin n_fail++; $display("FAIL f8_scheme got %0d exp 2", scheme); end
    load(15'h0005);  // no size bits: must not shrink
    n_checks++; if (scheme !== 3'd2) begin n_fail++; $display("FAIL f8_noshrink got %0d exp 2", scheme); end
    ld_active = 1'b0;
    strobe(13'h1FF9, 8'h00);
    n_checks++; if (bank !== 3'd1) begin n_fail++; $display("FAIL f8_bank1 got %0d exp 1", bank); end
    n_checks++; if (rom_addr !== 15'h0FF9) begin n_fail++; $display("FAIL f8_old_bank got %h exp 0ff9", rom_addr); end
    cpu_addr = 13'h1123;
    tick();
    n_checks++; if (rom_addr !== 15'h1123) begin n_fail++; $display("FAIL f8_rom got %h exp 1123", rom_addr); end
    strobe(13'h1FFA, 8'h00);
    n_checks++; if (bank !== 3'd1) begin n_fail++; $display("FAIL f8_nonhot got %0d exp 1", bank); end
    strobe(13'h1FF8, 8'h00);
    n_checks++; if (bank !== 3'd0) begin n_fail++; $display("FAIL f8_bank0 got %0d exp 0", bank); end
  endtask

  task automatic test_f4();
    load(15'h7FFF);
    n_checks++; if (scheme !== 3'd5) begin n_fail++; $display("FAIL f4_scheme got %0d exp 5", scheme); end
    strobe(13'h1FFB, 8'h00);
    n_checks++; if (bank !== 3'd7) begin n_fail++; $display("FAIL f4_bank7 got %0d exp 7", bank); end
    cpu_addr = 13'h1FFC;
    tick();
    n_checks++; if (rom_addr !== 15'h7FFC) begin n_fail++; $display("FAIL f4_rom got %h exp 7ffc", rom_addr); end
    strobe(13'h1FF5, 8'h00);
    n_checks++; if (bank !== 3'd1) begin n_fail++; $display("FAIL f4_bank1 got %0d exp 1", bank); end
    reset = 1'b1;
    strobe(13'h1FFA, 8'h00);  // hotspot in the reset cycle: reset wins
    n_checks++; if (bank !== 3'd0) begin n_fail++; $display("FAIL f4_rst_bank got %0d exp 0", bank); end
    n_checks++; if (scheme !== 3'd5) begin n_fail++; $display("FAIL f4_rst_scheme got %0d exp 5", scheme); end
    n_checks++; if (rom_addr !== 15'h0) begin n_fail++; $display("FAIL f4_rst_rom got %h exp 0000", rom_addr); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fe();
    load(15'h0000); load(15'h1FFF);
    fe_sel = 1'b1;
    #1;
    n_checks++; if (scheme !== 3'd3) begin n_fail++; $display("FAIL fe_scheme got %0d exp 3", scheme); end
    strobe(13'h01FE, 8'h00); strobe(13'h1000, 8'hD0);
    n_checks++; if (bank !== 3'd1) begin n_fail++; $display("FAIL fe_d0 got %0d exp 1", bank); end
    strobe(13'h01FE, 8'h00); strobe(13'h1000, 8'hF0);
    n_checks++; if (bank !== 3'd0) begin n_fail++; $display("FAIL fe_f0 got %0d exp 0", bank); end
    strobe(13'h01FE, 8'h00); strobe(13'h01FE, 8'hD0);
    n_checks++; if (bank !== 3'd1) begin n_fail++; $display("FAIL fe_rearm_apply got %0d exp 1", bank); end
    strobe(13'h1000, 8'hF0);
    n_checks++; if (bank !== 3'd0) begin n_fail++; $display("FAIL fe_rearm got %0d exp 0", bank); end
    strobe(13'h01FE, 8'h00); strobe(13'h1000, 8'hD0);
    strobe(13'h01FE, 8'h00);
    ld_active = 1'b1;
    tick();
    n_checks++; if (bank !== 3'd0) begin n_fail++; $display("FAIL fe_ld_bank got %0d exp 0", bank); end
    ld_active = 1'b0;
    strobe(13'h1000, 8'hD0);
    n_checks++; if (bank !== 3'd0) begin n_fail++; $display("FAIL fe_ld_idle got %0d exp 0", bank); end
    strobe(13'h01FE, 8'h00);
    fe_sel = 1'b0;
    tick();
    fe_sel = 1'b1;
    strobe(13'h1000, 8'hD0);
    n_checks++; if (bank !== 3'd0) begin n_fail++; $display("FAIL fe_sch_chg got %0d exp 0", bank); end
  endtask

  task automatic test_2k();
    load(15'h0000); load(15'h0400); load(15'h07FF);
    n_checks++; if (scheme !== 3'd0) begin n_fail++; $display("FAIL k2_scheme got %0d exp 0", scheme); end
    cpu_addr = 13'h1FFC;
    tick();
    n_checks++; if (rom_addr !== 15'h07FC) begin n_fail++; $display("FAIL k2_rom got %h exp 07fc", rom_addr); end
    strobe(13'h1FF9, 8'h00);
    n_checks++; if (bank !== 3'd0) begin n_fail++; $display("FAIL k2_bank got %0d exp 0", bank); end
    n_checks++; if (rom_addr !== 15'h07F9) begin n_fail++; $display("FAIL k2_rom2 got %h exp 07f9", rom_addr); end
  endtask

  task automatic test_f6();
    load(15'h3FFF);
    n_checks++; if (scheme !== 3'd4) begin n_fail++; $display("FAIL f6_scheme got %0d exp 4", scheme); end
    ld_active = 1'b1;
    strobe(13'h1FF7, 8'h00);
    n_checks++; if (bank !== 3'd0) begin n_fail++; $display("FAIL f6_ld got %0d exp 0", bank); end
    ld_active = 1'b0;
    strobe(13'h1FF7, 8'h00);
    n_checks++; if (bank !== 3'd1) begin n_fail++; $display("FAIL f6_1ff7 got %0d exp 1", bank); end
    strobe(13'h1FF9, 8'h00);
    n_checks++; if (bank !== 3'd3) begin n_fail++; $display("FAIL f6_1ff9 got %0d exp 3", bank); end
    cpu_addr = 13'h1010;
    tick();
    n_checks++; if (rom_addr !== 15'h3010) begin n_fail++; $display("FAIL f6_rom got %h exp 3010", rom_addr); end
  endtask

  task automatic test_superchip();
    load(15'h0000); load(15'h1FFF);
    fe_sel = 1'b0;
`ifdef SUPERCHIP_EN
    sc_en = 1'b1;
`endif
    cpu_strobe = 1'b1; cpu_rnw = 1'b0; cpu_addr = 13'h1005;
    #1;
`ifdef SUPERCHIP_EN
    n_checks++; if (cart_ram_cs !== 1'b1 || cart_ram_we !== 1'b1) begin
      n_fail++; $display("FAIL sc_wr got cs=%b we=%b exp 1/1", cart_ram_cs, cart_ram_we); end
    cpu_addr = 13'h1085;
    #1;
    n_checks++; if (cart_ram_cs !== 1'b1 || cart_ram_we !== 1'b0) begin
      n_fail++; $display("FAIL sc_rdport got cs=%b we=%b exp 1/0", cart_ram_cs, cart_ram_we); end
    sc_en = 1'b0; cpu_addr = 13'h1005;
    #1;
    n_checks++; if (cart_ram_cs !== 1'b0 || cart_ram_we !== 1'b0) begin
      n_fail++; $display("FAIL sc_off got cs=%b we=%b exp 0/0", cart_ram_cs, cart_ram_we); end
`else
    n_checks++; if (cart_ram_cs !== 1'b0 || cart_ram_we !== 1'b0) begin
      n_fail++; $display("FAIL sc_absent got cs=%b we=%b exp 0/0", cart_ram_cs, cart_ram_we); end
`endif
    tick();
    cpu_strobe = 1'b0; cpu_rnw = 1'b1;
  endtask

  initial begin
    test_reset();
    test_f8();
    test_f4();
    test_fe();
    test_2k();
    test_f6();
    test_superchip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
